// File: rtl/charmap_scroll_pipe.sv
// Character-map renderer with per-frame scroll: beam position -> RAM/ROM
// addresses -> RGB888 + fg flag, fixed 4-clock latency, 1 pixel/clock.
// Ports: clk, reset (async high), hcnt/vcnt/enable, scroll_x/y/wr,
//   chram_addr + RAM data in, chrom_addr + ROM data in, r/g/b/a out.
module charmap_scroll_pipe #(
  parameter int         COLS_LOG2  = 6,
  parameter int         ROWS_LOG2  = 6,
  parameter logic [8:0] LATCH_LINE = 9'd0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [8:0]                     hcnt,
  input  logic [8:0]                     vcnt,
  input  logic                           enable,
  input  logic [8:0]                     scroll_x,
  input  logic [8:0]                     scroll_y,
  input  logic                           scroll_wr,
  output logic [COLS_LOG2+ROWS_LOG2-1:0] chram_addr,
  input  logic [7:0]                     chmap_data_out,
  input  logic [7:0]                     fgcolram_data_out,
  input  logic [7:0]                     bgcolram_data_out,
  output logic [11:0]                    chrom_addr,
  input  logic [7:0]                     chrom_data_out,
  output logic [7:0]                     r,
  output logic [7:0]                     g,
  output logic [7:0]                     b,
  output logic                           a
);

  localparam int XW = COLS_LOG2 + 3;
  localparam int YW = ROWS_LOG2 + 3;

  logic [8:0]    pend_x, pend_y;
  logic [8:0]    act_x, act_y;
  logic          latch;
  logic [8:0]    sum_x, sum_y;
  logic [XW-1:0] ex;
  logic [YW-1:0] ey;

  logic [2:0]    s1_col, s1_row;
  logic          s1_en;
  logic [2:0]    s2_col, s2_row;
  logic          s2_en;
  logic [2:0]    s3_col;
  logic          s3_en;
  logic [7:0]    s3_fg, s3_bg;

  logic          pix;
  logic [7:0]    c;

  assign latch = (hcnt == 9'd0) && (vcnt == LATCH_LINE);

  // 9-bit sum, then fit to the map size: wrap, never clamp
  assign sum_x = hcnt + act_x;
  assign sum_y = vcnt + act_y;
  assign ex    = XW'(sum_x);
  assign ey    = YW'(sum_y);

  // latch reads pending before this edge's write lands
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_x <= '0;
      pend_y <= '0;
      act_x  <= '0;
      act_y  <= '0;
    end else begin
      if (scroll_wr) begin
        pend_x <= scroll_x;
        pend_y <= scroll_y;
      end
      if (latch) begin
        act_x <= pend_x;
        act_y <= pend_y;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chram_addr <= '0;
      s1_col     <= '0;
      s1_row     <= '0;
      s1_en      <= 1'b0;
      s2_col     <= '0;
      s2_row     <= '0;
      s2_en      <= 1'b0;
      s3_col     <= '0;
      s3_en      <= 1'b0;
      s3_fg      <= '0;
      s3_bg      <= '0;
    end else begin
      chram_addr <= {ey[YW-1:3], ex[XW-1:3]};
      s1_col     <= ex[2:0];
      s1_row     <= ey[2:0];
      s1_en      <= enable;
      s2_col     <= s1_col;
      s2_row     <= s1_row;
      s2_en      <= s1_en;
      s3_col     <= s2_col;
      s3_en      <= s2_en;
      s3_fg      <= fgcolram_data_out;
      s3_bg      <= bgcolram_data_out;
    end
  end

  // RAM data is live this cycle; held at 0 while in reset
  assign chrom_addr = reset ? 12'd0
                    : {1'b0, chmap_data_out, s2_row};

  // bit 7 is the leftmost pixel, so index = 7 - col = ~col
  assign pix = chrom_data_out[~s3_col];
  assign c   = pix ? s3_fg : s3_bg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r <= '0;
      g <= '0;
      b <= '0;
      a <= 1'b0;
    end else if (s3_en) begin
      r <= {c[2:0], c[2:0], 2'b00};
      g <= {c[5:3], c[5:3], 2'b00};
      b <= {c[7:6], c[7:6], c[7:6], 2'b00};
      a <= pix;
    end else begin
      r <= '0;
      g <= '0;
      b <= '0;
      a <= 1'b0;
    end
  end

endmodule

// File: tb/tb_charmap_scroll_pipe.sv
// Bench for charmap_scroll_pipe: default and 5x5-log2 maps side by side,
// shared RAM/ROM models with 1-cycle read latency.
module tb_charmap_scroll_pipe;

  logic        clk;
  logic        reset;
  logic [8:0]  hcnt, vcnt;
  logic        enable;
  logic [8:0]  scroll_x, scroll_y;
  logic        scroll_wr;

  logic [11:0] ca_a;
  logic [9:0]  ca_b;
  logic [11:0] cr_a, cr_b;
  logic [7:0]  ch_a, fg_a, bg_a, rq_a;
  logic [7:0]  ch_b, fg_b, bg_b, rq_b;
  logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b;
  logic        a_a, a_b;

  logic [7:0]  chmap [4096];
  logic [7:0]  fgc   [4096];
  logic [7:0]  bgc   [4096];
  logic [7:0]  rom   [4096];

  int total = 0;
  int bad   = 0;

  charmap_scroll_pipe dut_a (
    .clk(clk), .reset(reset), .hcnt(hcnt), .vcnt(vcnt),
    .enable(enable), .scroll_x(scroll_x), .scroll_y(scroll_y),
    .scroll_wr(scroll_wr), .chram_addr(ca_a),
    .chmap_data_out(ch_a), .fgcolram_data_out(fg_a),
    .bgcolram_data_out(bg_a), .chrom_addr(cr_a),
    .chrom_data_out(rq_a), .r(r_a), .g(g_a), .b(b_a), .a(a_a)
  );

  charmap_scroll_pipe #(.COLS_LOG2(5), .ROWS_LOG2(5)) dut_b (
    .clk(clk), .reset(reset), .hcnt(hcnt), .vcnt(vcnt),
    .enable(enable), .scroll_x(scroll_x), .scroll_y(scroll_y),
    .scroll_wr(scroll_wr), .chram_addr(ca_b),
    .chmap_data_out(ch_b), .fgcolram_data_out(fg_b),
    .bgcolram_data_out(bg_b), .chrom_addr(cr_b),
    .chrom_data_out(rq_b), .r(r_b), .g(g_b), .b(b_b), .a(a_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    ch_a <= chmap[ca_a];
    fg_a <= fgc[ca_a];
    bg_a <= bgc[ca_a];
    rq_a <= rom[cr_a];
    ch_b <= chmap[{2'b00, ca_b}];
    fg_b <= fgc[{2'b00, ca_b}];
    bg_b <= bgc[{2'b00, ca_b}];
    rq_b <= rom[cr_b];
  end

  typedef struct {
    logic [8:0]  h;
    logic [8:0]  v;
    logic        en;
    logic [11:0] ca_a;
    logic [9:0]  ca_b;
    logic [11:0] cr_a;
    logic [11:0] cr_b;
    logic [24:0] px_a;
    logic [24:0] px_b;
  } vec_t;

  vec_t tv [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pxa();
    return {7'd0, a_a, r_a, g_a, b_a};
  endfunction

  function automatic logic [31:0] pxb();
    return {7'd0, a_b, r_b, g_b, b_b};
  endfunction

  task automatic wr_scroll(input logic [8:0] x,
                           input logic [8:0] y);
    hcnt = 9'd5; vcnt = 9'd3;
    scroll_x = x; scroll_y = y; scroll_wr = 1'b1;
    tick();
    scroll_wr = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      chmap[i] = 8'h00; fgc[i] = 8'h00;
      bgc[i]   = 8'h00; rom[i] = 8'h00;
    end
    chmap[0] = 8'h41; chmap[1] = 8'h42; chmap[2] = 8'h43;
    fgc[0] = 8'h07; fgc[1] = 8'hC0; fgc[2] = 8'h38;
    bgc[2] = 8'h05;
    rom[12'h208] = 8'h80;
    for (int i = 0; i < 8; i++) rom[12'h210 + i] = 8'hFF;
    rom[12'h218] = 8'h01;

    tv[0] = '{9'd0,   9'd0,   1'b1, 12'h000, 10'h000,
              12'h208, 12'h208, 25'h1FC0000, 25'h1FC0000};
    tv[1] = '{9'd1,   9'd0,   1'b1, 12'h000, 10'h000,
              12'h208, 12'h208, 25'h0, 25'h0};
    tv[2] = '{9'd8,   9'd1,   1'b1, 12'h001, 10'h001,
              12'h211, 12'h211, 25'h10000FC, 25'h10000FC};
    tv[3] = '{9'd16,  9'd0,   1'b1, 12'h002, 10'h002,
              12'h218, 12'h218, 25'h0B40000, 25'h0B40000};
    tv[4] = '{9'd23,  9'd0,   1'b1, 12'h002, 10'h002,
              12'h218, 12'h218, 25'h100FC00, 25'h100FC00};
    tv[5] = '{9'd0,   9'd9,   1'b1, 12'h040, 10'h020,
              12'h001, 12'h001, 25'h0, 25'h0};
    tv[6] = '{9'd511, 9'd511, 1'b1, 12'hFFF, 10'h3FF,
              12'h007, 12'h007, 25'h0, 25'h0};
    tv[7] = '{9'd0,   9'd0,   1'b0, 12'h000, 10'h000,
              12'h208, 12'h208, 25'h0, 25'h0};
    tv[8] = '{9'd256, 9'd0,   1'b1, 12'h020, 10'h000,
              12'h000, 12'h208, 25'h0, 25'h1FC0000};

    reset = 1'b1; hcnt = '0; vcnt = '0; enable = 1'b1;
    scroll_x = '0; scroll_y = '0; scroll_wr = 1'b0;
    #12;
    chk("rst_ca_a", {20'd0, ca_a}, 32'h0);
    chk("rst_cr_a", {20'd0, cr_a}, 32'h0);
    chk("rst_px_a", pxa(), 32'h0);
    chk("rst_px_b", pxb(), 32'h0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      hcnt = tv[i].h; vcnt = tv[i].v; enable = tv[i].en;
      tick();
      chk($sformatf("v%0d_ca_a", i), {20'd0, ca_a}, {20'd0, tv[i].ca_a});
      chk($sformatf("v%0d_ca_b", i), {22'd0, ca_b}, {22'd0, tv[i].ca_b});
      tick();
      chk($sformatf("v%0d_cr_a", i), {20'd0, cr_a}, {20'd0, tv[i].cr_a});
      chk($sformatf("v%0d_cr_b", i), {20'd0, cr_b}, {20'd0, tv[i].cr_b});
      tick();
      tick();
      chk($sformatf("v%0d_px_a", i), pxa(), {7'd0, tv[i].px_a});
      chk($sformatf("v%0d_px_b", i), pxb(), {7'd0, tv[i].px_b});
    end

    // one-cycle enable drop inside a streaming run
    vcnt = 9'd1;
    hcnt = 9'd8;  enable = 1'b1; tick();
    hcnt = 9'd9;  enable = 1'b0; tick();
    hcnt = 9'd10; enable = 1'b1; tick();
    hcnt = 9'd11; tick();
    chk("en_prev", pxa(), 32'h10000FC);
    tick();
    chk("en_drop", pxa(), 32'h0);
    tick();
    chk("en_next", pxa(), 32'h10000FC);

    // scroll write, latch, wrap
    enable = 1'b1;
    wr_scroll(9'd8, 9'd0);
    hcnt = 9'd0; vcnt = 9'd3; tick();
    chk("sc_nolatch", {20'd0, ca_a}, 32'h0);
    hcnt = 9'd0; vcnt = 9'd0; tick();
    chk("sc_latchcyc", {20'd0, ca_a}, 32'h0);
    hcnt = 9'd0; vcnt = 9'd3; tick();
    chk("sc_x8_a", {20'd0, ca_a}, 32'h1);
    chk("sc_x8_b", {22'd0, ca_b}, 32'h1);
    wr_scroll(9'h1F8, 9'd0);
    hcnt = 9'd0; vcnt = 9'd0; tick();
    hcnt = 9'd16; vcnt = 9'd3; tick();
    chk("sc_wrap_a", {20'd0, ca_a}, 32'h1);
    chk("sc_wrap_b", {22'd0, ca_b}, 32'h1);

    // write coincident with latch
    wr_scroll(9'd24, 9'd0);
    hcnt = 9'd0; vcnt = 9'd0;
    scroll_x = 9'd16; scroll_y = 9'd8; scroll_wr = 1'b1;
    tick();
    scroll_wr = 1'b0;
    chk("co_cyc", {20'd0, ca_a}, 32'h03F);
    hcnt = 9'd0; vcnt = 9'd3; tick();
    chk("co_old", {20'd0, ca_a}, 32'h3);
    hcnt = 9'd0; vcnt = 9'd0; tick();
    hcnt = 9'd0; vcnt = 9'd3; tick();
    chk("co_new_a", {20'd0, ca_a}, 32'h042);
    chk("co_new_b", {22'd0, ca_b}, 32'h022);

    // async reset mid-stream, then restart
    #2 reset = 1'b1;
    #1;
    chk("mr_ca_a", {20'd0, ca_a}, 32'h0);
    chk("mr_ca_b", {22'd0, ca_b}, 32'h0);
    chk("mr_cr_a", {20'd0, cr_a}, 32'h0);
    chk("mr_px_a", pxa(), 32'h0);
    tick();
    reset = 1'b0;
    hcnt = 9'd0; vcnt = 9'd0; enable = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 1)
        chk("mr_scroll0", {20'd0, ca_a}, 32'h0);
      chk($sformatf("mr_px%0d", i), pxa(),
          (i == 4) ? 32'h1FC0000 : 32'h0);
      hcnt = 9'(i);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
